mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
Shares one multi-cycle multiplier engine between NREQ requesters. It picks one pending request by round-robin, accepts its operands and pulses the engine start. It then waits for engine done, with a watchdog, and returns the product to the granted requester. It sits between the requester clients and the engine's start/multiplicand/multiplier/done/product interface.

Parameters:
N, 8, operand width; the product is 2*N bits.
NREQ, 4, number of requesters (2..16).
TIMEOUT, 255, maximum number of cycles spent in WAIT before an error response.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NREQ  per-requester request pending.
req_a  input  NREQ*N  packed multiplicands; requester i uses bits [i*N +: N].
req_b  input  NREQ*N  packed multipliers; same packing as req_a.
req_ready  output  NREQ  one-hot accept pulse.
rsp_valid  output  NREQ  one-hot response pulse.
rsp_product  output  2*N  response product, shared by all requesters.
rsp_err  output  1  response is a timeout error; qualified by rsp_valid.
mul_start  output  1  engine start pulse.
mul_multiplicand  output  N  engine operand A.
mul_multiplier  output  N  engine operand B.
mul_done  input  1  engine completion pulse.
mul_product  input  2*N  engine result; valid when mul_done=1.
busy  output  1  high when state is not IDLE.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. On reset, all outputs go to 0, state=IDLE, rr_ptr=0, grant index=0, watchdog=0. Reset mid-operation aborts the transaction with no response. The engine shares rst_n.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE transition: if any req_valid is set, scan from rr_ptr upward modulo NREQ and take the first set bit g.
  - Drive req_ready[g]=1 combinationally in this cycle.
  - At the clock edge, latch req_a[g] into mul_multiplicand, req_b[g] into mul_multiplier, and g into the grant index.
  - Go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- req_ready:
  - Only ever high in IDLE, and at most one bit high.
  - A requester holds req_valid and its operands stable until req_ready is seen.
  - Deasserting req_valid before grant is legal; nothing is recorded.
- ISSUE: mul_start=1 for exactly this one cycle, then go to WAIT. Clear the watchdog.
- Operand stability: mul_multiplicand and mul_multiplier stay stable from ISSUE until the next grant, regardless of req_a/req_b changes.
- WAIT: the watchdog increments each cycle. Exits are checked in this order:
  - mul_done=1: capture mul_product into rsp_product, set rsp_err=0, go to RESP.
  - Otherwise, watchdog==TIMEOUT-1 (i.e. TIMEOUT WAIT cycles elapsed with no done): set rsp_product=0, rsp_err=1, go to RESP.
  - If mul_done arrives on the same cycle as the timeout condition, done wins.
- RESP: rsp_valid[g]=1 for exactly one cycle, with rsp_product and rsp_err registered and stable. Set rr_ptr=(g+1) mod NREQ and go to IDLE.
  - There is no response backpressure; a requester must accept the pulse.
- rsp_product/rsp_err outside RESP: these hold their last value and are meaningful only with rsp_valid.
- mul_done outside WAIT (spurious, or late after a timeout) is ignored.
- Latency and throughput:
  - Accept at edge T; mul_start high in cycle T+1.
  - rsp_valid is high one cycle after the cycle in which mul_done is sampled.
  - Minimum spacing between consecutive mul_start pulses is 3 cycles plus the engine latency. This guarantees the engine has returned to idle.
- Fairness: after a grant, the most recently served requester has the lowest priority. With all NREQ requesters continuously pending, each is served once per NREQ transactions.
- Watchdog width: clog2(TIMEOUT+1) bits; it must not wrap within WAIT.

Test Plan:
1. Single request, bench engine model with done 5 cycles after start. Drive req_valid=4'b0100, a=0x07, b=0x05, model product 0x0023.
   -> req_ready=4'b0100 for 1 cycle; mul_start for 1 cycle with operands 0x07/0x05; rsp_valid=4'b0100 for 1 cycle with rsp_product=0x0023, rsp_err=0; busy returns to 0.
2. After reset, req_valid=4'b1111 held continuously, with distinct operands per requester.
   -> Grants in order 0,1,2,3,0,1; each rsp_valid bit matches its own product; there is never more than one bit set in req_ready or rsp_valid.
3. Grant requester 2 first, then present req_valid=4'b1001.
   -> Requester 3 is granted before requester 0.
4. TIMEOUT=16, model never asserts done.
   -> rsp_valid pulses for the granted requester 16 WAIT cycles after ISSUE, with rsp_err=1 and rsp_product=0. A stray mul_done 3 cycles later is ignored: no rsp_valid, state remains IDLE.
5. Pull rst_n low 2 cycles into WAIT with requester 1 granted.
   -> All outputs go to 0 immediately (asynchronously) and no response is issued. After release with req_valid=4'b0011, requester 0 is granted first (rr_ptr reset to 0).
6. During WAIT, change req_a/req_b and pulse mul_done while in IDLE on a later transaction.
   -> mul_multiplicand/mul_multiplier stay unchanged until the next grant. The IDLE-time mul_done produces no response and no state change.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one multi-cycle multiplier between
// NREQ requesters, with a watchdog that turns a missing done into an error response.
module mult_share_arbiter #(
    parameter int N       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*N-1:0]      rsp_product,
    output logic                rsp_err,
    output logic                mul_start,
    output logic [N-1:0]        mul_multiplicand,
    output logic [N-1:0]        mul_multiplier,
    input  logic                mul_done,
    input  logic [2*N-1:0]      mul_product,
    output logic                busy
);
    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_gnt;
    logic [WW-1:0]      r_wdog;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic               r_start;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [2*N-1:0]     r_rsp_product;
    logic               r_rsp_err;
    logic               r_busy;

    logic               w_any;
    logic [IW-1:0]      w_pick;
    logic [NREQ-1:0]    w_ready;
    logic [NREQ-1:0]    w_gnt_oh;

    function automatic logic [IW-1:0] f_wrap(input int v);
        return IW'(v % NREQ);
    endfunction

    // Scan downward so the last hit written is the first set bit at or above rr_ptr.
    always_comb begin
        w_any  = |req_valid;
        w_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[f_wrap(int'(r_rr_ptr) + k)])
                w_pick = f_wrap(int'(r_rr_ptr) + k);
        end
    end

    // Gated by rst_n so the accept strobe also drops during reset.
    always_comb begin
        w_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_any)
            w_ready[w_pick] = 1'b1;
    end

    always_comb begin
        w_gnt_oh        = '0;
        w_gnt_oh[r_gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_gnt         <= '0;
            r_wdog        <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_start       <= 1'b0;
            r_rsp_valid   <= '0;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= req_a[w_pick*N +: N];
                        r_b     <= req_b[w_pick*N +: N];
                        r_gnt   <= w_pick;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over an expiring watchdog
                    if (mul_done) begin
                        r_rsp_product <= mul_product;
                        r_rsp_err     <= 1'b0;
                        r_rsp_valid   <= w_gnt_oh;
                        r_state       <= S_RESP;
                    end else if (r_wdog == WW'(TIMEOUT - 1)) begin
                        r_rsp_product <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_valid   <= w_gnt_oh;
                        r_state       <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= f_wrap(int'(r_gnt) + 1);
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready        = w_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_product      = r_rsp_product;
    assign rsp_err          = r_rsp_err;
    assign mul_start        = r_start;
    assign mul_multiplicand = r_a;
    assign mul_multiplier   = r_b;
    assign busy             = r_busy;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a fixed-latency engine model.
module tb_mult_share_arbiter;
    localparam int N = 8, NREQ = 4, TIMEOUT = 16, LAT = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*N-1:0] req_a = '0, req_b = '0;
    logic [NREQ-1:0]   req_ready, rsp_valid;
    logic [2*N-1:0]    rsp_product, mul_product;
    logic              rsp_err, mul_start, mul_done, busy;
    logic [N-1:0]      mul_multiplicand, mul_multiplier;

    logic [3:0]        eng_cnt;
    logic [2*N-1:0]    eng_prod;
    logic              eng_en = 1'b1;
    logic              tb_done = 1'b0;

    int n_cmp = 0, n_err = 0, viol = 0;

    mult_share_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
        .rsp_err(rsp_err), .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_done(mul_done), .mul_product(mul_product),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine model: done is high in the LAT-th cycle after the start cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt  <= '0;
            eng_prod <= '0;
        end else if (mul_start && eng_en) begin
            eng_cnt  <= 4'(LAT);
            eng_prod <= mul_multiplicand * mul_multiplier;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1'b1;
        end
    end
    assign mul_done    = (eng_cnt == 4'd1) | tb_done;
    assign mul_product = eng_prod;

    always @(negedge clk) begin
        if (rst_n && ($countones(req_ready) > 1 || $countones(rsp_valid) > 1))
            viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic wait_ready(output logic [3:0] r);
        r = '0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (req_ready != 0) begin
                r = req_ready;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid != 0) return;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One transaction; latency counted from the ISSUE cycle to the RESP cycle.
    task automatic xact(input string tag, input logic [3:0] rv, input logic [3:0] exp_gnt,
                        input logic [15:0] exp_prod, input logic exp_err, input int exp_lat,
                        input bit hold);
        logic [3:0] r;
        int n;
        req_valid = rv;
        wait_ready(r);
        chk({tag, "_ready"}, r, exp_gnt);
        @(negedge clk);
        if (!hold) req_valid = req_valid & ~r;
        chk({tag, "_start"}, mul_start, 1'b1);
        chk({tag, "_ready_drop"}, req_ready, 4'b0);
        wait_rsp(n);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_rsp_valid"}, rsp_valid, exp_gnt);
        chk({tag, "_product"}, rsp_product, exp_prod);
        chk({tag, "_err"}, rsp_err, exp_err);
        @(negedge clk);
        chk({tag, "_rsp_drop"}, rsp_valid, 4'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        logic [3:0] r;
        logic [15:0] prods [4] = '{16'h0006, 16'h000C, 16'h0014, 16'h001E};

        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 4'b0);
        chk("rst_rsp", rsp_valid, 4'b0);
        chk("rst_start", mul_start, 1'b0);
        chk("rst_ops", {mul_multiplicand, mul_multiplier}, 16'h0);

        // T1: single request
        set_op(2, 8'h07, 8'h05);
        req_valid = 4'b0100;
        #1 chk("t1_ready_comb", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        chk("t1_start", mul_start, 1'b1);
        chk("t1_opa", mul_multiplicand, 8'h07);
        chk("t1_opb", mul_multiplier, 8'h05);
        chk("t1_busy", busy, 1'b1);
        @(negedge clk);
        chk("t1_start_drop", mul_start, 1'b0);
        wait_rsp(n);
        chk("t1_lat", n, 5);
        chk("t1_rsp_valid", rsp_valid, 4'b0100);
        chk("t1_product", rsp_product, 16'h0023);
        chk("t1_err", rsp_err, 1'b0);
        @(negedge clk);
        chk("t1_rsp_drop", rsp_valid, 4'b0);
        chk("t1_idle", busy, 1'b0);

        // T2: all pending, round-robin 0,1,2,3,0,1
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 2), 8'(i + 3));
        for (int t = 0; t < 6; t++)
            xact($sformatf("t2_%0d", t), 4'b1111, 4'(1 << (t % 4)), prods[t % 4], 1'b0, 6, 1'b1);
        req_valid = '0;

        // T3: after serving 2, 3 beats 0
        xact("t3_a", 4'b0100, 4'b0100, 16'h0014, 1'b0, 6, 1'b0);
        xact("t3_b", 4'b1001, 4'b1000, 16'h001E, 1'b0, 6, 1'b0);
        xact("t3_c", 4'b0001, 4'b0001, 16'h0006, 1'b0, 6, 1'b0);

        // T4: engine silent -> timeout error, then stray done ignored
        eng_en = 1'b0;
        xact("t4", 4'b0010, 4'b0010, 16'h0000, 1'b1, TIMEOUT + 1, 1'b0);
        repeat (2) @(negedge clk);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        chk("t4_stray_rsp", rsp_valid, 4'b0);
        chk("t4_stray_busy", busy, 1'b0);
        @(negedge clk);
        chk("t4_stray_rsp2", rsp_valid, 4'b0);
        eng_en = 1'b1;

        // T5: reset two cycles into WAIT
        req_valid = 4'b0010;
        wait_ready(r);
        chk("t5_ready", r, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b0011;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_start", mul_start, 1'b0);
        chk("t5_ops", {mul_multiplicand, mul_multiplier}, 16'h0);
        chk("t5_err", rsp_err, 1'b0);
        chk("t5_rsp", rsp_valid, 4'b0);
        chk("t5_ready_rst", req_ready, 4'b0);
        repeat (2) @(negedge clk);
        chk("t5_rsp_hold", rsp_valid, 4'b0);
        rst_n = 1'b1;
        #1 chk("t5_ready_after", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        chk("t5_lat", n, 6);
        chk("t5_rsp_valid", rsp_valid, 4'b0001);
        chk("t5_product", rsp_product, 16'h0006);

        // T6: operands held through WAIT; IDLE-time done ignored
        @(negedge clk);
        set_op(2, 8'h04, 8'h05);
        req_valid = 4'b0100;
        wait_ready(r);
        chk("t6_ready", r, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        chk("t6_opa", mul_multiplicand, 8'h04);
        @(negedge clk);
        req_a = '1;
        req_b = '1;
        @(negedge clk);
        chk("t6_opa_hold", mul_multiplicand, 8'h04);
        chk("t6_opb_hold", mul_multiplier, 8'h05);
        wait_rsp(n);
        chk("t6_lat", n, 4);
        chk("t6_product", rsp_product, 16'h0014);
        @(negedge clk);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        chk("t6_stray_rsp", rsp_valid, 4'b0);
        chk("t6_stray_busy", busy, 1'b0);
        chk("t6_opa_idle", mul_multiplicand, 8'h04);
        @(negedge clk);
        chk("t6_stray_rsp2", rsp_valid, 4'b0);
        xact("t6_new", 4'b0001, 4'b0001, 16'hFE01, 1'b0, 6, 1'b0);
        chk("t6_opa_new", mul_multiplicand, 8'hFF);

        chk("onehot", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
